// File: rtl/tff_bank_sequencer_pkg.sv
// Shared encodings for the TFF bank sequencer: command modes, FSM states
// and the step-count width.
package tff_seq_pkg;

  localparam int RUN_LEN_W = 8;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/tff_bank_sequencer_tff_sync.sv
// Single toggle flip-flop with synchronous active-high reset; one cell of
// the sequencer's count bank.
module TFF_Sync (
  input  logic clk,
  input  logic reset,
  input  logic T,
  output logic Q
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset)  Q <= 1'b0;
    else if (T) Q <= ~Q;
  end

endmodule

// File: rtl/tff_bank_sequencer.sv
// Command-driven controller that turns a bank of toggle flops into a
// modulo-MODULUS up/down counter by choosing which cells toggle each cycle.
module tff_bank_sequencer
  import tff_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [RUN_LEN_W-1:0] run_len,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap
);

  localparam logic [WIDTH:0]     MOD_MAX = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH:0]     ONE_EXT = (WIDTH + 1)'(1);
  localparam logic [RUN_LEN_W-1:0] ONE_RL = RUN_LEN_W'(1);

  state_e               state, state_next;
  mode_e                mode_q;
  logic [RUN_LEN_W-1:0] remaining;
  logic [WIDTH-1:0]     t_vec;
  logic                 wrap_step;

  // Next-value arithmetic is one bit wider so MODULUS = 2^WIDTH never aliases.
  logic [WIDTH:0] q_ext, up_ext, down_ext;

  assign q_ext    = {1'b0, count};
  assign up_ext   = (q_ext >= MOD_MAX) ? '0 : q_ext + ONE_EXT;
  assign down_ext = (q_ext == '0 || q_ext > MOD_MAX) ? MOD_MAX : q_ext - ONE_EXT;

  assign busy = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    t_vec      = '0;
    wrap_step  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start)
          state_next = (mode == MODE_CLEAR || run_len != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        case (mode_q)
          MODE_UP: begin
            t_vec     = count ^ WIDTH'(up_ext);
            wrap_step = (q_ext == MOD_MAX);
          end
          MODE_DOWN: begin
            t_vec     = count ^ WIDTH'(down_ext);
            wrap_step = (q_ext == '0);
          end
          MODE_CLEAR: t_vec = count;
          default:    t_vec = '0;
        endcase
        if (remaining == ONE_RL) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Command latch, step counter and the registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_HOLD;
      remaining <= '0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      wrap <= wrap_step;
      if (state == S_IDLE && start) begin
        mode_q    <= mode_e'(mode);
        remaining <= (mode == MODE_CLEAR) ? ONE_RL : run_len;
      end else if (state == S_RUN) begin
        remaining <= remaining - ONE_RL;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    TFF_Sync u_cell (
      .clk   (clk),
      .reset (reset),
      .T     (t_vec[i]),
      .Q     (count[i])
    );
  end

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Directed bench for tff_bank_sequencer (WIDTH=4, MODULUS=10) with
// hand-computed expectations, sampled 1ns after each rising edge.
module tb_tff_bank_sequencer;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_UP    = 2'b01;
  localparam logic [1:0] M_DOWN  = 2'b10;
  localparam logic [1:0] M_CLEAR = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] run_len = 8'd0;
  logic [3:0] count;
  logic       busy, done, wrap;

  int checks = 0;
  int errors = 0;

  tff_bank_sequencer #(.WIDTH(4), .MODULUS(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .run_len (run_len),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge (edge k); returns 1ns after it.
  task automatic issue(input logic [1:0] m, input logic [7:0] len);
    start   = 1'b1;
    mode    = m;
    run_len = len;
    tick();
    start = 1'b0;
  endtask

  // Issue and let the command run to completion and back to IDLE.
  task automatic do_cmd(input logic [1:0] m, input logic [7:0] len);
    issue(m, len);
    repeat (int'(len) + 2) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if ({busy, done, wrap} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: busy/done/wrap got %b expected 000", {busy, done, wrap});
    end
    tick();
    checks++;
    if (count !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: count=%0d busy=%b expected 0/0", count, busy);
    end
  endtask

  task automatic test_up();
    int exp_c[3] = '{1, 2, 3};
    int busy_cycles = 0;
    int done_pulses = 0;
    issue(M_UP, 8'd3);
    checks++;
    if (busy !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL up_accept: busy=%b count=%0d expected 1/0", busy, count);
    end
    busy_cycles += int'(busy);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 4'(exp_c[i])) begin
        errors++; $display("FAIL up_step%0d: count=%0d expected %0d", i + 1, count, exp_c[i]);
      end
      checks++;
      if (busy !== (i < 2) || done !== 1'b0 || wrap !== 1'b0) begin
        errors++; $display("FAIL up_flags%0d: busy/done/wrap=%b%b%b expected %b00", i + 1, busy, done, wrap, (i < 2));
      end
      busy_cycles += int'(busy);
      done_pulses += int'(done);
    end
    tick();
    done_pulses += int'(done);
    checks++;
    if (done !== 1'b1 || count !== 4'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL up_done: done=%b count=%0d busy=%b expected 1/3/0", done, count, busy);
    end
    tick();
    done_pulses += int'(done);
    checks++;
    if (done_pulses != 1) begin errors++; $display("FAIL up_done_once: pulses=%0d expected 1", done_pulses); end
    checks++;
    if (busy_cycles != 3) begin errors++; $display("FAIL up_busy_len: cycles=%0d expected 3", busy_cycles); end
  endtask

  task automatic test_wrap_up();
    int exp_c[3] = '{9, 0, 1};
    logic exp_w[3] = '{1'b0, 1'b1, 1'b0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_cmd(M_UP, 8'd8);
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL preload8: count=%0d expected 8", count); end
    issue(M_UP, 8'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 4'(exp_c[i]) || wrap !== exp_w[i]) begin
        errors++; $display("FAIL upwrap_step%0d: count=%0d wrap=%b expected %0d/%b", i + 1, count, wrap, exp_c[i], exp_w[i]);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || wrap !== 1'b0) begin
      errors++; $display("FAIL upwrap_done: done=%b wrap=%b expected 1/0", done, wrap);
    end
    tick();
  endtask

  task automatic test_wrap_down();
    int exp_c[3] = '{0, 9, 8};
    logic exp_w[3] = '{1'b0, 1'b1, 1'b0};
    issue(M_DOWN, 8'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 4'(exp_c[i]) || wrap !== exp_w[i]) begin
        errors++; $display("FAIL down_step%0d: count=%0d wrap=%b expected %0d/%b", i + 1, count, wrap, exp_c[i], exp_w[i]);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL down_done: done=%b expected 1", done); end
    tick();
  endtask

  task automatic test_clear_hold();
    do_cmd(M_DOWN, 8'd1);
    checks++;
    if (count !== 4'd7) begin errors++; $display("FAIL preload7: count=%0d expected 7", count); end
    issue(M_CLEAR, 8'd200);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy: busy=%b expected 1", busy); end
    tick();
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL clear_step: count=%0d busy=%b done=%b expected 0/0/0", count, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL clear_done: done=%b count=%0d expected 1/0", done, count);
    end
    tick();
    do_cmd(M_UP, 8'd4);
    checks++;
    if (count !== 4'd4) begin errors++; $display("FAIL preload4: count=%0d expected 4", count); end
    issue(M_HOLD, 8'd5);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (count !== 4'd4 || done !== 1'b0 || busy !== (i < 5)) begin
        errors++; $display("FAIL hold_cyc%0d: count=%0d done=%b busy=%b expected 4/0/%b", i, count, done, busy, (i < 5));
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || count !== 4'd4) begin
      errors++; $display("FAIL hold_done: done=%b count=%0d expected 1/4", done, count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // UP by 2 from 4; start stays high (as CLEAR) through RUN and DONE.
    start   = 1'b1;
    mode    = M_UP;
    run_len = 8'd2;
    tick();
    mode    = M_CLEAR;
    run_len = 8'd9;
    tick();
    checks++;
    if (count !== 4'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL ign_step1: count=%0d busy=%b expected 5/1", count, busy);
    end
    tick();
    checks++;
    if (count !== 4'd6 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_step2: count=%0d busy=%b expected 6/0", count, busy);
    end
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd6) begin
      errors++; $display("FAIL ign_done: done=%b busy=%b count=%0d expected 1/0/6", done, busy, count);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd6) begin
      errors++; $display("FAIL ign_after: done=%b busy=%b count=%0d expected 0/0/6", done, busy, count);
    end
    issue(M_UP, 8'd0);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL zero_accept: busy=%b done=%b expected 0/0", busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd6) begin
      errors++; $display("FAIL zero_done: done=%b busy=%b count=%0d expected 1/0/6", done, busy, count);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_once: done=%b expected 0", done); end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    issue(M_UP, 8'd6);
    tick();
    tick();
    tick();
    checks++;
    if (count !== 4'd9) begin errors++; $display("FAIL mid_step3: count=%0d expected 9", count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (count !== 4'd0 || {busy, done, wrap} !== 3'b000) begin
      errors++; $display("FAIL mid_reset: count=%0d busy/done/wrap=%b expected 0/000", count, {busy, done, wrap});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      done_seen += int'(done) + int'(busy);
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL mid_no_done: done/busy cycles=%0d expected 0", done_seen); end
    issue(M_UP, 8'd1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL post_busy: busy=%b expected 1", busy); end
    tick();
    checks++;
    if (count !== 4'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_step: count=%0d busy=%b expected 1/0", count, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL post_done: done=%b expected 1", done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_up();
    test_wrap_up();
    test_wrap_down();
    test_clear_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
